// File: rtl/led_pattern_counter.sv
// led_pattern_counter: prescaled WIDTH-bit LED pattern counter with
// up, down, bounce and Gray modes, synchronous load and enable-pause.
// All outputs are registered.
// Optional feature macro: LED_PATTERN_COUNTER_SYNC_EN. When it is defined,
// en, mode and load pass through 2-flop synchronisers before use.
module led_pattern_counter #(
  parameter int WIDTH = 5,
  parameter int DIV   = 12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic             en_s;
  logic [1:0]       mode_s;
  logic             load_s;

  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [PW-1:0]    pre, pre_nx;
  dir_t             dir, dir_nx;
  logic [WIDTH-1:0] led_nx;
  logic             tick_nx;

`ifdef LED_PATTERN_COUNTER_SYNC_EN
  logic [1:0] en_sr;
  logic [1:0] load_sr;
  logic [1:0] mode_q1;
  logic [1:0] mode_q2;

  // two-flop synchronisers for the asynchronous control inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_sr   <= '0;
      load_sr <= '0;
      mode_q1 <= '0;
      mode_q2 <= '0;
    end else begin
      en_sr   <= {en_sr[0], en};
      load_sr <= {load_sr[0], load};
      mode_q1 <= mode;
      mode_q2 <= mode_q1;
    end
  end

  assign en_s   = en_sr[1];
  assign load_s = load_sr[1];
  assign mode_s = mode_q2;
`else
  assign en_s   = en;
  assign load_s = load;
  assign mode_s = mode;
`endif

  // next-state: load beats step beats hold; dir only survives in bounce
  always_comb begin
    cnt_nx  = cnt;
    pre_nx  = pre;
    dir_nx  = dir;
    tick_nx = 1'b0;
    if (load_s) begin
      cnt_nx = load_val;
      pre_nx = '0;
      dir_nx = DIR_UP;
    end else if (en_s) begin
      if (pre == PRE_MAX) begin
        pre_nx  = '0;
        tick_nx = 1'b1;
        case (mode_s)
          MODE_DOWN: cnt_nx = cnt - 1'b1;
          MODE_BOUNCE: begin
            if (dir == DIR_UP) begin
              if (cnt == CNT_MAX) begin
                cnt_nx = cnt - 1'b1;
                dir_nx = DIR_DOWN;
              end else begin
                cnt_nx = cnt + 1'b1;
              end
            end else begin
              if (cnt == '0) begin
                cnt_nx = cnt + 1'b1;
                dir_nx = DIR_UP;
              end else begin
                cnt_nx = cnt - 1'b1;
              end
            end
          end
          default: cnt_nx = cnt + 1'b1;
        endcase
      end else begin
        pre_nx = pre + PW'(1);
      end
    end
    if (mode_s != MODE_BOUNCE) dir_nx = DIR_UP;
    led_nx = (mode_s == MODE_GRAY) ? (cnt_nx ^ (cnt_nx >> 1)) : cnt_nx;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      pre  <= '0;
      dir  <= DIR_UP;
      led  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nx;
      pre  <= pre_nx;
      dir  <= dir_nx;
      led  <= led_nx;
      tick <= tick_nx;
    end
  end

endmodule

// File: tb/tb_led_pattern_counter.sv
// Directed bench for led_pattern_counter with WIDTH=4, DIV=3.
module tb_led_pattern_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] led;
  logic       tick;

  int tests;
  int fails;

  led_pattern_counter #(.WIDTH(4), .DIV(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .tick     (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n clock edges, leaving time 1 unit after the last edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'd0;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (led !== 4'd0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: led=%0d tick=%0b, want led=0 tick=0", led, tick);
    end
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic test_up();
    do_reset();
    mode = 2'b00;
    en   = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      cyc(2);
      tests++;
      if (tick !== 1'b0) begin
        fails++;
        $display("FAIL up_tick_low step %0d: tick=%0b, want 0", k, tick);
      end
      cyc(1);
      tests++;
      if (tick !== 1'b1 || led !== 4'(k % 16)) begin
        fails++;
        $display("FAIL up_step %0d: led=%0d tick=%0b, want led=%0d tick=1", k, led, tick, k % 16);
      end
    end
  endtask

  task automatic test_down_pause();
    do_reset();
    mode = 2'b01;
    en   = 1'b1;
    cyc(3);
    tests++;
    if (tick !== 1'b1 || led !== 4'd15) begin
      fails++;
      $display("FAIL down_first: led=%0d tick=%0b, want led=15 tick=1", led, tick);
    end
    cyc(1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      tests++;
      if (tick !== 1'b0 || led !== 4'd15) begin
        fails++;
        $display("FAIL pause_hold %0d: led=%0d tick=%0b, want led=15 tick=0", i, led, tick);
      end
    end
    en = 1'b1;
    cyc(1);
    tests++;
    if (tick !== 1'b0) begin
      fails++;
      $display("FAIL pause_early: tick=%0b, want 0", tick);
    end
    cyc(1);
    tests++;
    if (tick !== 1'b1 || led !== 4'd14) begin
      fails++;
      $display("FAIL pause_resume: led=%0d tick=%0b, want led=14 tick=1", led, tick);
    end
    // drop en exactly when pre sits at its terminal value
    cyc(2);
    en = 1'b0;
    cyc(3);
    tests++;
    if (tick !== 1'b0 || led !== 4'd14) begin
      fails++;
      $display("FAIL en_fall_at_max: led=%0d tick=%0b, want led=14 tick=0", led, tick);
    end
    en = 1'b1;
    cyc(1);
    tests++;
    if (tick !== 1'b1 || led !== 4'd13) begin
      fails++;
      $display("FAIL en_return_step: led=%0d tick=%0b, want led=13 tick=1", led, tick);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [19];
    exp_seq = '{4'd14, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd7,
                4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1, 4'd2};
    do_reset();
    mode = 2'b10;
    load_val = 4'd13;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    tests++;
    if (led !== 4'd13 || tick !== 1'b0) begin
      fails++;
      $display("FAIL bounce_load: led=%0d tick=%0b, want led=13 tick=0", led, tick);
    end
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cyc(3);
      tests++;
      if (tick !== 1'b1 || led !== exp_seq[i]) begin
        fails++;
        $display("FAIL bounce_step %0d: led=%0d tick=%0b, want led=%0d tick=1", i, led, tick, exp_seq[i]);
      end
    end
    // reach 5 while descending, then detour through mode 00
    load_val = 4'd15;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cyc(3);
      tests++;
      if (led !== 4'(15 - k)) begin
        fails++;
        $display("FAIL bounce_desc %0d: led=%0d, want %0d", k, led, 15 - k);
      end
    end
    mode = 2'b00;
    cyc(1);
    mode = 2'b10;
    tests++;
    if (led !== 4'd5 || tick !== 1'b0) begin
      fails++;
      $display("FAIL bounce_detour: led=%0d tick=%0b, want led=5 tick=0", led, tick);
    end
    cyc(2);
    tests++;
    if (tick !== 1'b1 || led !== 4'd6) begin
      fails++;
      $display("FAIL bounce_restart_up: led=%0d tick=%0b, want led=6 tick=1", led, tick);
    end
  endtask

  task automatic test_gray();
    logic [3:0] exp_seq [8];
    exp_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    do_reset();
    mode = 2'b11;
    en   = 1'b1;
    tests++;
    if (led !== 4'd0) begin
      fails++;
      $display("FAIL gray_start: led=%0d, want 0", led);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(3);
      tests++;
      if (tick !== 1'b1 || led !== exp_seq[i]) begin
        fails++;
        $display("FAIL gray_step %0d: led=%0d tick=%0b, want led=%0d tick=1", i, led, tick, exp_seq[i]);
      end
    end
    load_val = 4'd5;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    tests++;
    if (led !== 4'd7) begin
      fails++;
      $display("FAIL gray_load5: led=%0d, want 7", led);
    end
    mode = 2'b00;
    cyc(1);
    tests++;
    if (led !== 4'd5 || tick !== 1'b0) begin
      fails++;
      $display("FAIL gray_to_up_remap: led=%0d tick=%0b, want led=5 tick=0", led, tick);
    end
    cyc(2);
    tests++;
    if (tick !== 1'b1 || led !== 4'd6) begin
      fails++;
      $display("FAIL gray_to_up_step: led=%0d tick=%0b, want led=6 tick=1", led, tick);
    end
  endtask

  task automatic test_load_and_async_reset();
    do_reset();
    mode = 2'b00;
    en   = 1'b1;
    cyc(2);
    load_val = 4'd9;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    tests++;
    if (led !== 4'd9 || tick !== 1'b0) begin
      fails++;
      $display("FAIL load_beats_step: led=%0d tick=%0b, want led=9 tick=0", led, tick);
    end
    cyc(2);
    tests++;
    if (tick !== 1'b0) begin
      fails++;
      $display("FAIL load_no_early_tick: tick=%0b, want 0", tick);
    end
    cyc(1);
    tests++;
    if (tick !== 1'b1 || led !== 4'd10) begin
      fails++;
      $display("FAIL load_next_step: led=%0d tick=%0b, want led=10 tick=1", led, tick);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (led !== 4'd0 || tick !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: led=%0d tick=%0b, want led=0 tick=0", led, tick);
    end
    cyc(1);
    rst = 1'b1;
    cyc(2);
    tests++;
    if (tick !== 1'b0 || led !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_early: led=%0d tick=%0b, want led=0 tick=0", led, tick);
    end
    cyc(1);
    tests++;
    if (tick !== 1'b1 || led !== 4'd1) begin
      fails++;
      $display("FAIL post_reset_step: led=%0d tick=%0b, want led=1 tick=1", led, tick);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_up();
    test_down_pause();
    test_bounce();
    test_gray();
    test_load_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_counter.md
# led_pattern_counter

Parametrised LED pattern generator for the iCE40 board designs: a programmable prescaler drives a WIDTH-bit counter that runs in up, down, bounce or Gray mode, with synchronous load and pause. It replaces fixed free-running LED counters at the top level, driving board LEDs directly from `led`. Outputs are fully registered.

## Interface
- `WIDTH`, 5: counter and LED width; must be at least 2.
- `DIV`, 12000000: prescaler ratio, one step every DIV enabled cycles; must be at least 1; prescaler width is clog2(DIV), minimum 1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable; when low, prescaler and counter hold.
- `mode`  in  2  00 up, 01 down, 10 bounce, 11 Gray up.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value loaded into the binary count.
- `led`  out  WIDTH  pattern output.
- `tick`  out  1  single-cycle pulse, coincident with each new `led` value from a step.

## Operation
- Internal state:
  - binary count `cnt` (WIDTH bits)
  - prescaler `pre`
  - direction flag `dir` (UP/DOWN)
- Reset (`rst`=0, asynchronous) sets `cnt`=0, `pre`=0, `dir`=UP, `led`=0, `tick`=0. Release is sampled on `clk`; the first step happens DIV enabled cycles after release.
- Priority per edge: reset > load > step > hold.
- Load (`load`=1):
  - `cnt` <= `load_val`, `pre` <= 0, `dir` <= UP, `tick` <= 0.
  - Applies regardless of `en`.
- Prescaler:
  - When `en`=1 and `load`=0, `pre` increments.
  - On the edge where `pre`==DIV-1, `pre` wraps to 0 and a step occurs.
  - When `en`=0, `pre` holds its value, so a pause resumes mid-period.
- Step, by mode:
  - 00 up: `cnt`+1 modulo 2^WIDTH, so all-ones wraps to 0.
  - 01 down: `cnt`-1 modulo 2^WIDTH, so 0 wraps to all-ones.
  - 10 bounce, `dir`=UP: `cnt`+1. At `cnt`=2^WIDTH-1 the step goes to 2^WIDTH-2 and sets `dir`=DOWN.
  - 10 bounce, `dir`=DOWN: `cnt`-1. At `cnt`=0 the step goes to 1 and sets `dir`=UP.
  - 11 Gray: `cnt`+1 modulo 2^WIDTH, identical to up mode.
- Direction flag: `dir` is forced to UP on any edge where `mode`!=10, so entering bounce always starts ascending.
- Output mapping:
  - `led` = `cnt` in modes 00, 01 and 10.
  - `led` = `cnt` ^ (`cnt`>>1) in mode 11.
  - `led` is registered from the next-state value, so it always equals the mapping of the current `cnt`.
- Mode changes take effect on the same edge: `led` remaps immediately, and the step rule changes at the next step. A mode change never alters `cnt`.
- `tick` <= 1 on the edge where a step occurs, and 0 otherwise.

## Timing
- Step latency: `led` and `tick` update on the edge where `pre`==DIV-1 with `en`=1. `tick` is high for exactly the following cycle.
- DIV=1: a step occurs on every enabled edge, and `tick` stays high continuously while `en`=1.
- Load: `led` shows `load_val` (or its Gray mapping) one cycle after the `load` edge. The next step follows DIV enabled cycles later.
- `en` falling on the edge where `pre`==DIV-1: no step occurs and `pre` holds at DIV-1. The step fires on the first enabled edge after `en` returns.
- Load and step on the same edge: the load wins and `tick`=0.
- Reset asserted mid-period: all state clears immediately, without waiting for `clk`.

## Configuration
- `LED_PATTERN_COUNTER_SYNC_EN`
  - Defined: `en`, `mode` and `load` each pass through a 2-flop synchroniser clocked by `clk` and reset to 0 by `rst`. All responses above then occur 2 cycles later than stated, measured from the raw input.
  - Undefined: inputs are used directly and are required to be synchronous to `clk`.
  - `load_val` is never synchronised and must be stable while `load` is asserted.

## Test plan
All scenarios use WIDTH=4, DIV=3, with the macro undefined unless stated.
- Reset then `en`=1, mode 00: `tick` pulses every 3 cycles. `led` steps 0,1,…,15,0, and wraps after 16 ticks.
- Mode 01 from reset: first step gives `led`=15, then 14. Drop `en` for 5 cycles mid-period: `pre` holds and the step lands exactly 5 cycles late.
- Mode 10 after loading 13: `led` sequence 14,15,14,13,…,1,0,1,2. Switch to mode 00 and back to 10 while at 5 and descending: the next step gives 6.
- Mode 11 from reset: `led` sequence 0,1,3,2,6,7,5,4,12. Switch to mode 00 while `cnt`=5: `led` changes from 7 to 5 on that edge, with no step.
- Assert `load`, `load_val`=9, on the edge where `pre`==2: `led`=9 and `tick`=0, and the next tick arrives 3 cycles later with `led`=10. Assert `rst` mid-period: `led`=0 and `tick`=0 asynchronously.
- With `LED_PATTERN_COUNTER_SYNC_EN` defined: raise `en` at cycle 0 after reset; the first `tick` appears at cycle 5 instead of cycle 3.
